// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and default widths for the fetch/data memory arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which requester owns the current memory transaction
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,   // nothing in flight, requests sampled here only
        ARB_IBUSY,  // fetch transaction waiting for m_ack
        ARB_DBUSY,  // data transaction waiting for m_ack
        ARB_RESP    // drdy pulse to the granted port
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port (i_*), load/store port (d_*) and
// memory-side handshake (m_*) of the arbiter.
//   modport master : the arbiter's view (drives drdy/rdata and m_* request)
//   slave          : the environment's view (requesters + memory)
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);
    // fetch port
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_drdy;
    logic [DATA_W-1:0]     i_rdata;
    // load/store port
    logic                  d_req;
    logic [ADDR_W-1:0]     d_addr;
    logic                  d_write;
    logic [DATA_W/8-1:0]   d_be;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_drdy;
    logic [DATA_W-1:0]     d_rdata;
    // memory side
    logic                  m_req;
    logic [ADDR_W-1:0]     m_addr;
    logic                  m_write;
    logic [DATA_W/8-1:0]   m_be;
    logic [DATA_W-1:0]     m_wdata;
    logic                  m_ack;
    logic [DATA_W-1:0]     m_rdata;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_addr, d_write, d_be, d_wdata,
        input  m_ack, m_rdata,
        output i_drdy, i_rdata,
        output d_drdy, d_rdata,
        output m_req, m_addr, m_write, m_be, m_wdata
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_addr, d_write, d_be, d_wdata,
        output m_ack, m_rdata,
        input  i_drdy, i_rdata,
        input  d_drdy, d_rdata,
        input  m_req, m_addr, m_write, m_be, m_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr2.sv
// arb_rr2: combinational two-way round-robin pick.
//   i_req, d_req : pending requests
//   last_grant   : port granted most recently
//   grant        : port to grant now (only meaningful when a request is pending)
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  grant_t last_grant,
    output grant_t grant
);

    always_comb begin
        grant = GNT_I;
        if (i_req && d_req)
            // contention: hand the memory to whoever did not have it last
            grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
        else if (d_req)
            grant = GNT_D;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch port and the
// load/store port, one transaction at a time, alternating under contention.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_arbiter_if.master (i_* fetch, d_* data, m_* memory handshake)
// A transaction: grant in ARB_IDLE, hold m_req in ARB_IBUSY/ARB_DBUSY until
// m_ack, then one drdy cycle in ARB_RESP. Requests are only looked at in
// ARB_IDLE, so a request still held during ARB_RESP cannot be granted twice.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t state;
    grant_t     last_grant;
    grant_t     pick;

    // fetch addresses are word aligned; the low bits are dropped on purpose
    logic unused_i_addr_lo;
    assign unused_i_addr_lo = &{1'b0, bus.i_addr[1:0]};

    arb_rr2 u_rr2 (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB_IDLE;
            last_grant  <= GNT_I;       // data wins the first contention
            bus.m_req   <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_write <= 1'b0;
            bus.m_be    <= '0;
            bus.m_wdata <= '0;
            bus.i_drdy  <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_drdy  <= 1'b0;
            bus.d_rdata <= '0;
        end else begin
            // drdy is a single-cycle pulse raised on m_ack
            bus.i_drdy <= 1'b0;
            bus.d_drdy <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        last_grant <= pick;
                        bus.m_req  <= 1'b1;
                        if (pick == GNT_I) begin
                            bus.m_addr  <= {bus.i_addr[ADDR_W-1:2], 2'b00};
                            bus.m_be    <= {BE_W{1'b1}};
                            bus.m_write <= 1'b0;
                            bus.m_wdata <= '0;
                            state       <= ARB_IBUSY;
                        end else begin
                            bus.m_addr  <= bus.d_addr;
                            bus.m_be    <= bus.d_be;
                            bus.m_write <= bus.d_write;
                            bus.m_wdata <= bus.d_wdata;
                            state       <= ARB_DBUSY;
                        end
                    end
                end

                ARB_IBUSY: begin
                    if (bus.m_ack) begin
                        bus.i_rdata <= bus.m_rdata;
                        bus.i_drdy  <= 1'b1;
                        bus.m_req   <= 1'b0;
                        state       <= ARB_RESP;
                    end
                end

                ARB_DBUSY: begin
                    if (bus.m_ack) begin
                        // stores report zero rather than whatever the bus returns
                        bus.d_rdata <= bus.m_write ? '0 : bus.m_rdata;
                        bus.d_drdy  <= 1'b1;
                        bus.m_req   <= 1'b0;
                        state       <= ARB_RESP;
                    end
                end

                ARB_RESP: begin
                    // drdy is high this cycle; m_* fields keep the last values
                    state <= ARB_IDLE;
                end

                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
